// File: rtl/uart_tx_arbiter_if.sv
// Signal bundle between the byte producers, the UART transmit arbiter and the
// transmitter's enable/data inputs.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   grant;
    logic [ID_W-1:0]    grant_id;
    logic               busy;
    logic               frame_done;
    logic               uart_en;
    logic [7:0]         tx_data;

    modport master (
        output req, req_data,
        input  grant, grant_id, busy, frame_done, uart_en, tx_data
    );

    modport slave (
        input  req, req_data,
        output grant, grant_id, busy, frame_done, uart_en, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one open-loop UART transmitter between N_REQ
// byte producers; each grant owns a fixed frame slot timed from the baud rate.
module uart_tx_arbiter #(
    parameter int N_REQ    = 4,
    parameter int BAUD     = 115200,
    parameter int CLK_frq  = 100000000,
    parameter int GAP_BITS = 1
) (
    input  logic              sys_clk,
    input  logic              rst,
    uart_tx_arbiter_if.slave  bus
);
    localparam int BIT_CYC  = CLK_frq / BAUD;
    localparam int EN_CYC   = 2 * BIT_CYC;
    localparam int SLOT_CYC = (13 + GAP_BITS) * BIT_CYC;
    localparam int CNT_W    = $clog2(SLOT_CYC);
    localparam int ID_W     = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [7:0]         tx_q, tx_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic               busy_q, busy_d;
    logic               en_q, en_d;
    logic               done_q, done_d;
    logic [ID_W:0]      pick;
    logic [ID_W-1:0]    win;

    // First requester after 'last' in circular order; MSB flags a hit.
    function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [ID_W-1:0]  last);
        logic [ID_W:0] res;
        int            idx;
        res = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = (int'(last) + i) % N_REQ;
            if (r[idx[ID_W-1:0]]) res = {1'b1, idx[ID_W-1:0]};
        end
        return res;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        id_d    = id_q;
        tx_d    = tx_q;
        grant_d = '0;
        busy_d  = busy_q;
        en_d    = en_q;
        done_d  = 1'b0;
        pick    = rr_pick(bus.req, last_q);
        win     = pick[ID_W-1:0];

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                en_d   = 1'b0;
                if (pick[ID_W]) begin
                    state_d      = LAUNCH;
                    grant_d[win] = 1'b1;
                    tx_d         = bus.req_data[{win, 3'b000} +: 8];
                    id_d         = win;
                    last_d       = win;
                    cnt_d        = '0;
                    busy_d       = 1'b1;
                    en_d         = 1'b1;
                end
            end
            LAUNCH: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(EN_CYC - 1)) begin
                    state_d = WAIT;
                    en_d    = 1'b0;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Registered, so it must be raised one count early to land on the last slot cycle.
                if (cnt_q == CNT_W'(SLOT_CYC - 2)) done_d = 1'b1;
                if (cnt_q == CNT_W'(SLOT_CYC - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                en_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= ID_W'(N_REQ - 1);
            id_q    <= '0;
            tx_q    <= 8'h00;
            grant_q <= '0;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            id_q    <= id_d;
            tx_q    <= tx_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            en_q    <= en_d;
            done_q  <= done_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.grant_id   = id_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
    assign bus.uart_en    = en_q;
    assign bus.tx_data    = tx_q;
endmodule
